// File: rtl/sfx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfx_pkg
// Description : Shared constants and types for the sound-effect scheduler:
//               effect ids, FSM state encoding, note indices, tone
//               half-periods and the pattern ROM entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package sfx_pkg;

    // Effect ids; the numeric value also orders priority (higher wins)
    localparam logic [1:0] SFX_NONE  = 2'd0;
    localparam logic [1:0] SFX_JUMP  = 2'd1;
    localparam logic [1:0] SFX_SCORE = 2'd2;
    localparam logic [1:0] SFX_OVER  = 2'd3;

    // Scheduler FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Note indices stored in the pattern ROM
    localparam logic [2:0] NOTE_C4 = 3'd0;
    localparam logic [2:0] NOTE_C5 = 3'd1;
    localparam logic [2:0] NOTE_E5 = 3'd2;
    localparam logic [2:0] NOTE_G5 = 3'd3;
    localparam logic [2:0] NOTE_C6 = 3'd4;
    localparam logic [2:0] NOTE_E6 = 3'd5;
    localparam logic [2:0] NOTE_G6 = 3'd6;
    localparam logic [2:0] NOTE_C7 = 3'd7;

    // Tone half-periods in 25.175 MHz clock cycles
    localparam logic [15:0] HP_C4 = 16'd48112;
    localparam logic [15:0] HP_C5 = 16'd24056;
    localparam logic [15:0] HP_E5 = 16'd19093;
    localparam logic [15:0] HP_G5 = 16'd16056;
    localparam logic [15:0] HP_C6 = 16'd12028;
    localparam logic [15:0] HP_E6 = 16'd9547;
    localparam logic [15:0] HP_G6 = 16'd8028;
    localparam logic [15:0] HP_C7 = 16'd6014;

    // One pattern step: which note, how many game ticks, final step marker
    typedef struct packed {
        logic [2:0] note;
        logic [3:0] ticks;
        logic       last;
    } sfx_entry_t;

    // Map a note index to its half-period
    function automatic logic [15:0] note_half(input logic [2:0] note);
        logic [15:0] hp;
        case (note)
            NOTE_C4: hp = HP_C4;
            NOTE_C5: hp = HP_C5;
            NOTE_E5: hp = HP_E5;
            NOTE_G5: hp = HP_G5;
            NOTE_C6: hp = HP_C6;
            NOTE_E6: hp = HP_E6;
            NOTE_G6: hp = HP_G6;
            default: hp = HP_C7;
        endcase
        return hp;
    endfunction

    // Highest-priority pending id; bit0=jump, bit1=score, bit2=over
    function automatic logic [1:0] sfx_pick(input logic [2:0] pend);
        logic [1:0] id;
        if (pend[2])      id = SFX_OVER;
        else if (pend[1]) id = SFX_SCORE;
        else if (pend[0]) id = SFX_JUMP;
        else              id = SFX_NONE;
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfx_scheduler_pattern_rom.sv
`default_nettype none
// ============================================================================
// Module      : sfx_pattern_rom
// Description : Combinational pattern ROM, (effect id, step index) -> entry.
//               The score pattern exists only when SFX_MILESTONE_EN is
//               defined. Unused slots return a one-tick final step so a
//               stray lookup always terminates the pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module sfx_pattern_rom
    import sfx_pkg::*;
(
    input  logic [1:0]  id,
    input  logic [1:0]  idx,
    output sfx_entry_t  entry
);

    // Pattern table lookup
    always_comb begin
        entry = '{note: NOTE_C4, ticks: 4'd1, last: 1'b1};
        case (id)
            SFX_JUMP: begin
                case (idx)
                    2'd0:    entry = '{note: NOTE_C6, ticks: 4'd2, last: 1'b0};
                    2'd1:    entry = '{note: NOTE_E6, ticks: 4'd2, last: 1'b1};
                    default: entry = '{note: NOTE_C4, ticks: 4'd1, last: 1'b1};
                endcase
            end
`ifdef SFX_MILESTONE_EN
            SFX_SCORE: begin
                case (idx)
                    2'd0:    entry = '{note: NOTE_E6, ticks: 4'd3, last: 1'b0};
                    2'd1:    entry = '{note: NOTE_G6, ticks: 4'd3, last: 1'b0};
                    2'd2:    entry = '{note: NOTE_C7, ticks: 4'd6, last: 1'b1};
                    default: entry = '{note: NOTE_C4, ticks: 4'd1, last: 1'b1};
                endcase
            end
`endif
            SFX_OVER: begin
                case (idx)
                    2'd0:    entry = '{note: NOTE_G5, ticks: 4'd6,  last: 1'b0};
                    2'd1:    entry = '{note: NOTE_E5, ticks: 4'd6,  last: 1'b0};
                    2'd2:    entry = '{note: NOTE_C5, ticks: 4'd6,  last: 1'b0};
                    default: entry = '{note: NOTE_C4, ticks: 4'd15, last: 1'b1};
                endcase
            end
            default: entry = '{note: NOTE_C4, ticks: 4'd1, last: 1'b1};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sfx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sfx_scheduler
// Description : Latches jump / score / game-over sound requests, arbitrates
//               them by fixed priority (over > score > jump, only over
//               preempts) and plays the selected multi-note pattern as a
//               square wave on the single speaker output. Note lengths are
//               counted in 60 Hz game ticks.
//               Optional macro SFX_MILESTONE_EN enables the score channel.
// Revision    : 1.0 - initial release
// ============================================================================
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int HALF_PER_W = 16,
    parameter int GAP_TICKS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_tick,
    input  logic       req_over,
    input  logic       req_score,
    input  logic       req_jump,
    input  logic       mute,
    output logic       sound,
    output logic       busy,
    output logic [1:0] active_id
);

    localparam int GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

    logic [1:0]            state_q, state_d;
    logic [2:0]            pend_q, pend_d;
    logic [1:0]            active_id_q, active_id_d;
    logic [1:0]            idx_q, idx_d;
    logic [HALF_PER_W-1:0] half_q, half_d;
    logic [HALF_PER_W-1:0] cnt_q, cnt_d;
    logic [3:0]            dur_q, dur_d;
    logic                  last_q, last_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  tone_q, tone_d;
    logic                  sound_q, sound_d;
    logic                  busy_q, busy_d;

    logic                  w_req_score;
    logic                  w_preempt;
    logic                  w_note_end;
    logic                  w_gap_end;
    logic [1:0]            w_grant_id;
    sfx_entry_t            w_entry;

`ifdef SFX_MILESTONE_EN
    assign w_req_score = req_score;
`else
    assign w_req_score = req_score & 1'b0;
`endif

    // Only over preempts, and only a pattern other than itself
    assign w_preempt  = pend_q[2] && (active_id_q != SFX_OVER) &&
                        ((state_q == ST_PLAY) || (state_q == ST_GAP));
    assign w_note_end = (state_q == ST_PLAY) && game_tick && (dur_q <= 4'd1);
    assign w_gap_end  = (state_q == ST_GAP) && game_tick && (gap_q <= GAP_W'(1));
    assign w_grant_id = w_preempt ? SFX_OVER :
                        (state_q == ST_IDLE) ? sfx_pick(pend_q) : SFX_NONE;

    sfx_pattern_rom u_rom (
        .id    (active_id_q),
        .idx   (idx_q),
        .entry (w_entry)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pend_q != 3'b000) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_PLAY;
            ST_PLAY: begin
                if (w_preempt)        state_d = ST_LOAD;
                else if (w_note_end)  state_d = last_q ? ST_IDLE :
                                                (GAP_TICKS == 0) ? ST_LOAD : ST_GAP;
            end
            default: begin
                if (w_preempt || w_gap_end) state_d = ST_LOAD;
            end
        endcase
    end

    // Datapath: pending flags, pattern step, tone and duration counters
    always_comb begin
        active_id_d = active_id_q;
        idx_d       = idx_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        dur_d       = dur_q;
        last_d      = last_q;
        gap_d       = gap_q;
        tone_d      = tone_q;

        // A request for the effect now playing is dropped; the grant clears
        pend_d[0] = (pend_q[0] | (req_jump    && active_id_q != SFX_JUMP))
                    & (w_grant_id != SFX_JUMP);
        pend_d[1] = (pend_q[1] | (w_req_score && active_id_q != SFX_SCORE))
                    & (w_grant_id != SFX_SCORE);
        pend_d[2] = (pend_q[2] | (req_over    && active_id_q != SFX_OVER))
                    & (w_grant_id != SFX_OVER);

        if (w_grant_id != SFX_NONE) begin
            active_id_d = w_grant_id;
            idx_d       = 2'd0;
            tone_d      = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    half_d = HALF_PER_W'(note_half(w_entry.note));
                    dur_d  = w_entry.ticks;
                    last_d = w_entry.last;
                    cnt_d  = '0;
                    tone_d = 1'b0;
                end
                ST_PLAY: begin
                    if (cnt_q == half_q - HALF_PER_W'(1)) begin
                        cnt_d  = '0;
                        tone_d = ~tone_q;
                    end else begin
                        cnt_d  = cnt_q + HALF_PER_W'(1);
                    end
                    if (game_tick) dur_d = dur_q - 4'd1;
                    if (w_note_end) begin
                        dur_d  = 4'd0;
                        tone_d = 1'b0;
                        gap_d  = GAP_W'(GAP_TICKS);
                        if (last_q)               active_id_d = SFX_NONE;
                        else if (GAP_TICKS == 0)  idx_d = idx_q + 2'd1;
                    end
                end
                ST_GAP: begin
                    tone_d = 1'b0;
                    if (game_tick) gap_d = gap_q - GAP_W'(1);
                    if (w_gap_end) idx_d = idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // FSM outputs, computed from the next state so they register glitch-free
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        sound_d = tone_d && (state_d == ST_PLAY) && !mute;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            active_id_q <= SFX_NONE;
            idx_q       <= '0;
            half_q      <= '0;
            cnt_q       <= '0;
            dur_q       <= '0;
            last_q      <= 1'b0;
            gap_q       <= '0;
            tone_q      <= 1'b0;
            sound_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            active_id_q <= active_id_d;
            idx_q       <= idx_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            dur_q       <= dur_d;
            last_q      <= last_d;
            gap_q       <= gap_d;
            tone_q      <= tone_d;
            sound_q     <= sound_d;
            busy_q      <= busy_d;
        end
    end

    assign sound     = sound_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;

endmodule
`default_nettype wire
